// File: rtl/dfp_pkg.sv
// Shared DFP line-master types: FSM state encoding, bus beat width and a beat-drive helper.
package dfp_pkg;

   localparam int BEAT_W = 32;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      ADDR,
      WDATA,
      RWAIT,
      RDATA,
      RESP
   } state_e;

   // Selects the beat to put on the bus, or an idle (all-zero) bus when not driving.
   function automatic logic [BEAT_W-1:0] beat_sel(input logic [BEAT_W-1:0] beat, input logic drive);
      return drive ? beat : '0;
   endfunction

endpackage

// File: rtl/dfp_line_if.sv
// Cache-side line request/response plus the 32-bit DFP burst bus; master = line master, slave = its environment.
interface dfp_line_if #(
   parameter int BURSTS = 4,
   parameter int LINE_W = 32 * BURSTS
);
   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [31:0]       req_addr;
   logic [LINE_W-1:0] req_wdata;
   logic              rsp_valid;
   logic [LINE_W-1:0] rsp_rdata;
   logic              rsp_err;
   logic              dfp_read;
   logic              dfp_write;
   logic [31:0]       dfp_wdata;
   logic              dfp_ack;
   logic              dfp_resp;
   logic [31:0]       dfp_rdata;

   modport master (
      input  req_valid, req_write, req_addr, req_wdata, dfp_ack, dfp_resp, dfp_rdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err, dfp_read, dfp_write, dfp_wdata
   );

   modport slave (
      output req_valid, req_write, req_addr, req_wdata, dfp_ack, dfp_resp, dfp_rdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err, dfp_read, dfp_write, dfp_wdata
   );
endinterface

// File: rtl/dfp_line_shifter.sv
// Line buffer: parallel load then shift-out (beat 0 first) for writes, shift-in for reads; shared beat counter.
// Single-cycle register updates, no flow control of its own (the FSM sequences every shift).
module dfp_line_shifter import dfp_pkg::*; #(
   parameter int BURSTS = 4,
   parameter int LINE_W = BEAT_W * BURSTS,
   parameter int CNT_W  = $clog2(BURSTS) + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic [LINE_W-1:0] load_line,
   input  logic              shift_out,
   input  logic              shift_in,
   input  logic [BEAT_W-1:0] beat_in,
   input  logic              cnt_clr,
   input  logic              cnt_inc,
   output logic [BEAT_W-1:0] beat_out,
   output logic [LINE_W-1:0] line_shifted_in,
   output logic              last
);
   logic [LINE_W-1:0] line_q, line_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   assign beat_out        = line_q[BEAT_W-1:0];
   // New beats enter at the top so that after BURSTS captures beat 0 sits at the bottom.
   assign line_shifted_in = {beat_in, line_q[LINE_W-1:BEAT_W]};
   assign last            = (cnt_q == CNT_W'(BURSTS - 1));

   always_comb begin
      line_d = line_q;
      if (load) begin
         line_d = load_line;
      end else if (shift_out) begin
         line_d = {{BEAT_W{1'b0}}, line_q[LINE_W-1:BEAT_W]};
      end else if (shift_in) begin
         line_d = line_shifted_in;
      end

      cnt_d = cnt_q;
      if (cnt_clr) begin
         cnt_d = '0;
      end else if (cnt_inc) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         line_q <= '0;
         cnt_q  <= '0;
      end else begin
         line_q <= line_d;
         cnt_q  <= cnt_d;
      end
   end
endmodule

// File: rtl/dfp_line_master.sv
// Serialises one cache-line request onto the DFP burst bus; zero-stall latency write 3+BURSTS, read 4+BURSTS.
// Accepts only in IDLE, rsp_valid is a single unstalled pulse; DFP_ECHO_CHECK_EN enables echo/gap error reporting.
module dfp_line_master import dfp_pkg::*; #(
   parameter int BURSTS = 4,
   parameter int LINE_W = BEAT_W * BURSTS
) (
   input logic        clk,
   input logic        rst_n,
   dfp_line_if.master bus
);
   localparam int OFF_W = $clog2(4 * BURSTS);

   state_e            state_q, state_d;
   logic              write_q, write_d;
   logic [31:0]       addr_q, addr_d;
   logic              req_ready_q, req_ready_d;
   logic              dfp_read_q, dfp_read_d;
   logic              dfp_write_q, dfp_write_d;
   logic [31:0]       dfp_wdata_q, dfp_wdata_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [LINE_W-1:0] rsp_rdata_q, rsp_rdata_d;
`ifdef DFP_ECHO_CHECK_EN
   logic              err_q, err_d;
   logic              rsp_err_q, rsp_err_d;
`endif

   logic              sh_load, sh_shift_out, sh_shift_in, sh_cnt_clr, sh_cnt_inc, sh_last;
   logic [BEAT_W-1:0] sh_beat_out;
   logic [LINE_W-1:0] sh_line_in;

   dfp_line_shifter #(.BURSTS(BURSTS), .LINE_W(LINE_W)) u_shifter (
      .clk            (clk),
      .rst_n          (rst_n),
      .load           (sh_load),
      .load_line      (bus.req_wdata),
      .shift_out      (sh_shift_out),
      .shift_in       (sh_shift_in),
      .beat_in        (bus.dfp_rdata),
      .cnt_clr        (sh_cnt_clr),
      .cnt_inc        (sh_cnt_inc),
      .beat_out       (sh_beat_out),
      .line_shifted_in(sh_line_in),
      .last           (sh_last)
   );

   always_comb begin
      state_d      = state_q;
      write_d      = write_q;
      addr_d       = addr_q;
      req_ready_d  = req_ready_q;
      dfp_read_d   = dfp_read_q;
      dfp_write_d  = dfp_write_q;
      dfp_wdata_d  = dfp_wdata_q;
      rsp_valid_d  = 1'b0;
      rsp_rdata_d  = '0;
      sh_load      = 1'b0;
      sh_shift_out = 1'b0;
      sh_shift_in  = 1'b0;
      sh_cnt_clr   = 1'b0;
      sh_cnt_inc   = 1'b0;
`ifdef DFP_ECHO_CHECK_EN
      err_d        = err_q;
      rsp_err_d    = 1'b0;
`endif
      case (state_q)
         IDLE: if (bus.req_valid) begin
            state_d     = REQ;
            write_d     = bus.req_write;
            addr_d      = {bus.req_addr[31:OFF_W], {OFF_W{1'b0}}};
            req_ready_d = 1'b0;
            dfp_read_d  = !bus.req_write;
            dfp_write_d = bus.req_write;
            sh_load     = 1'b1;
`ifdef DFP_ECHO_CHECK_EN
            err_d       = 1'b0;
`endif
         end
         REQ: if (bus.dfp_ack) begin
            state_d     = ADDR;
            dfp_read_d  = 1'b0;
            dfp_write_d = 1'b0;
            dfp_wdata_d = addr_q;
         end
         ADDR: begin
            // Writes put beat 0 straight after the address; reads idle the bus.
            state_d      = write_q ? WDATA : RWAIT;
            dfp_wdata_d  = beat_sel(sh_beat_out, write_q);
            sh_shift_out = write_q;
            sh_cnt_clr   = 1'b1;
         end
         WDATA: begin
            dfp_wdata_d  = beat_sel(sh_beat_out, !sh_last);
            sh_shift_out = !sh_last;
            sh_cnt_inc   = !sh_last;
            if (sh_last) begin
               state_d     = RESP;
               rsp_valid_d = 1'b1;
`ifdef DFP_ECHO_CHECK_EN
               rsp_err_d   = err_q;
`endif
            end
         end
         RWAIT: if (bus.dfp_resp) begin
            state_d    = RDATA;
            sh_cnt_clr = 1'b1;
`ifdef DFP_ECHO_CHECK_EN
            err_d      = err_q | (bus.dfp_rdata != addr_q);
`endif
         end
         RDATA: begin
            if (bus.dfp_resp) begin
               sh_shift_in = 1'b1;
               sh_cnt_inc  = 1'b1;
               if (sh_last) begin
                  state_d     = RESP;
                  rsp_valid_d = 1'b1;
                  rsp_rdata_d = sh_line_in;
`ifdef DFP_ECHO_CHECK_EN
                  rsp_err_d   = err_q;
`endif
               end
            end else begin
`ifdef DFP_ECHO_CHECK_EN
               err_d = 1'b1;
`endif
            end
         end
         RESP: begin
            state_d     = IDLE;
            req_ready_d = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         write_q     <= 1'b0;
         addr_q      <= '0;
         req_ready_q <= 1'b1;
         dfp_read_q  <= 1'b0;
         dfp_write_q <= 1'b0;
         dfp_wdata_q <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
`ifdef DFP_ECHO_CHECK_EN
         err_q       <= 1'b0;
         rsp_err_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         write_q     <= write_d;
         addr_q      <= addr_d;
         req_ready_q <= req_ready_d;
         dfp_read_q  <= dfp_read_d;
         dfp_write_q <= dfp_write_d;
         dfp_wdata_q <= dfp_wdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
`ifdef DFP_ECHO_CHECK_EN
         err_q       <= err_d;
         rsp_err_q   <= rsp_err_d;
`endif
      end
   end

   assign bus.req_ready = req_ready_q;
   assign bus.dfp_read  = dfp_read_q;
   assign bus.dfp_write = dfp_write_q;
   assign bus.dfp_wdata = dfp_wdata_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rsp_rdata_q;
`ifdef DFP_ECHO_CHECK_EN
   assign bus.rsp_err   = rsp_err_q;
`else
   assign bus.rsp_err   = 1'b0;
`endif
endmodule

// File: tb/tb_dfp_line_master.sv
// Bench for dfp_line_master: behavioural DFP memory with configurable stalls, bus-beat and response scoreboards.
module tb_dfp_line_master;
   localparam int BURSTS = 4;
   localparam int LINE_W = 32 * BURSTS;
`ifdef DFP_ECHO_CHECK_EN
   localparam bit ECHO_ERR = 1'b1;
`else
   localparam bit ECHO_ERR = 1'b0;
`endif
   localparam logic [127:0] L1 = 128'h44444444_33333333_22222222_11111111;
   localparam logic [127:0] L2 = 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0;
   localparam logic [127:0] L3 = 128'h33330003_22220002_11110001_00000000;
   localparam logic [127:0] L4 = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;

   typedef struct {
      logic [127:0] rdata;
      logic         err;
      int           acc;
      int           lat;
   } rsp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   dfp_line_if #(.BURSTS(BURSTS), .LINE_W(LINE_W)) bus ();
   dfp_line_master #(.BURSTS(BURSTS), .LINE_W(LINE_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   rsp_t         sb[$];
   logic [31:0]  exp_bus[$];
   logic [127:0] mem [logic [31:0]];
   int           ack_stall = 0;
   int           resp_stall = 0;
   bit           corrupt = 1'b0;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(string name, logic [127:0] act, logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic pop_bus(string name, logic [31:0] act);
      logic [31:0] e;
      tests++;
      if (exp_bus.size() == 0) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected no beat", name, act);
      end else begin
         e = exp_bus.pop_front();
         if (act !== e) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, e);
         end
      end
   endtask

   // Memory side: ack after ack_stall cycles, echo after resp_stall cycles, beats back to back.
   task automatic serve();
      bit           wr;
      logic [31:0]  a;
      logic [127:0] line, tmp;
      wr = bus.dfp_write;
      for (int i = 0; i < ack_stall; i++) begin
         check("req_held", 128'(wr ? bus.dfp_write : bus.dfp_read), 128'(1));
         step();
      end
      bus.dfp_ack = 1'b1;
      step();
      bus.dfp_ack = 1'b0;
      check("req_drop", 128'({bus.dfp_read, bus.dfp_write}), 128'(0));
      a = bus.dfp_wdata;
      pop_bus("bus_addr", a);
      if (wr) begin
         line = '0;
         for (int k = 0; k < BURSTS; k++) begin
            step();
            if (!rst_n) return;
            line = {bus.dfp_wdata, line[127:32]};
            pop_bus("bus_wbeat", bus.dfp_wdata);
         end
         mem[a] = line;
      end else begin
         step();
         check("no_rearm", 128'(bus.dfp_read), 128'(0));
         for (int i = 0; i < resp_stall; i++) begin
            step();
            check("no_rearm", 128'(bus.dfp_read), 128'(0));
         end
         line = mem.exists(a) ? mem[a] : '0;
         bus.dfp_resp  = 1'b1;
         bus.dfp_rdata = corrupt ? 32'h2000 : a;
         for (int k = 0; k < BURSTS; k++) begin
            step();
            tmp = line >> (32 * k);
            bus.dfp_rdata = tmp[31:0];
         end
         step();
         bus.dfp_resp  = 1'b0;
         bus.dfp_rdata = '0;
      end
   endtask

   initial begin : mem_model
      bus.dfp_ack   = 1'b0;
      bus.dfp_resp  = 1'b0;
      bus.dfp_rdata = '0;
      forever begin
         step();
         if (rst_n && (bus.dfp_read || bus.dfp_write)) serve();
      end
   end

   initial begin : rsp_monitor
      forever begin
         rsp_t e;
         step();
         if (bus.dfp_read || bus.dfp_write) begin
            tests++;
            if (bus.dfp_read && bus.dfp_write) begin
               fails++;
               $display("FAIL rd_wr_exclusive: got both 1, expected at most one");
            end
         end
         if (bus.rsp_valid) begin
            if (sb.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL rsp_unexpected: got rsp_valid=1, expected no response");
            end else begin
               e = sb.pop_front();
               check("rsp_rdata", bus.rsp_rdata, e.rdata);
               check("rsp_err", 128'(bus.rsp_err), 128'(e.err));
               if (e.lat > 0) check("rsp_latency", 128'(cyc - e.acc), 128'(e.lat));
            end
         end
      end
   end

   task automatic issue(bit wr, logic [31:0] addr, logic [31:0] bus_addr, logic [127:0] wdata,
                        logic [127:0] exp_rdata, bit exp_err, int lat);
      int           n;
      rsp_t         e;
      logic [127:0] tmp;
      bus.req_valid = 1'b1;
      bus.req_write = wr;
      bus.req_addr  = addr;
      bus.req_wdata = wdata;
      n = 0;
      while (!bus.req_ready && n < 100) begin
         step();
         n++;
      end
      if (!bus.req_ready) begin
         tests++;
         fails++;
         $display("FAIL req_accept: got req_ready=0 for 100 cycles, expected 1");
         bus.req_valid = 1'b0;
         return;
      end
      exp_bus.push_back(bus_addr);
      if (wr) begin
         for (int k = 0; k < BURSTS; k++) begin
            tmp = wdata >> (32 * k);
            exp_bus.push_back(tmp[31:0]);
         end
      end
      e.rdata = exp_rdata;
      e.err   = exp_err;
      e.acc   = cyc;
      e.lat   = lat;
      sb.push_back(e);
      step();
      bus.req_valid = 1'b0;
      n = 0;
      while (sb.size() != 0 && n < 300) begin
         step();
         n++;
      end
      if (sb.size() != 0) begin
         tests++;
         fails++;
         $display("FAIL rsp_timeout: got no rsp_valid in 300 cycles, expected one");
         sb.delete();
      end
   endtask

   initial begin : stimulus
      bus.req_valid = 1'b0;
      bus.req_write = 1'b0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      mem[32'h2000] = L4;
      repeat (3) @(posedge clk);
      #1;
      check("rst_dfp_read", 128'(bus.dfp_read), 128'(0));
      check("rst_dfp_write", 128'(bus.dfp_write), 128'(0));
      check("rst_dfp_wdata", 128'(bus.dfp_wdata), 128'(0));
      check("rst_rsp_valid", 128'(bus.rsp_valid), 128'(0));
      check("rst_rsp_rdata", bus.rsp_rdata, 128'(0));
      check("rst_rsp_err", 128'(bus.rsp_err), 128'(0));
      rst_n = 1'b1;
      step();
      check("idle_req_ready", 128'(bus.req_ready), 128'(1));

      issue(1'b1, 32'h1000, 32'h1000, L1, 128'(0), 1'b0, 7);
      issue(1'b0, 32'h1000, 32'h1000, 128'(0), L1, 1'b0, 8);
      issue(1'b0, 32'h100C, 32'h1000, 128'(0), L1, 1'b0, 8);

      ack_stall  = $urandom_range(1, 8);
      resp_stall = $urandom_range(1, 8);
      issue(1'b1, 32'h2040, 32'h2040, L2, 128'(0), 1'b0, 0);
      ack_stall  = $urandom_range(1, 8);
      resp_stall = $urandom_range(1, 8);
      issue(1'b0, 32'h2044, 32'h2040, 128'(0), L2, 1'b0, 0);
      ack_stall  = 0;
      resp_stall = 0;

      corrupt = 1'b1;
      issue(1'b0, 32'h1000, 32'h1000, 128'(0), L1, ECHO_ERR, 8);
      corrupt = 1'b0;

      ack_stall = 8;
      issue(1'b0, 32'h1000, 32'h1000, 128'(0), L1, 1'b0, 16);
      ack_stall = 0;

      // Write to 0x3000 abandoned by a reset pulse during data beat 2.
      step();
      bus.req_valid = 1'b1;
      bus.req_write = 1'b1;
      bus.req_addr  = 32'h3000;
      bus.req_wdata = L3;
      exp_bus.push_back(32'h3000);
      exp_bus.push_back(32'h00000000);
      exp_bus.push_back(32'h11110001);
      exp_bus.push_back(32'h22220002);
      exp_bus.push_back(32'h33330003);
      step();
      bus.req_valid = 1'b0;
      repeat (4) @(posedge clk);
      #3;
      check("beat2_before_reset", 128'(bus.dfp_wdata), 128'(32'h22220002));
      rst_n = 1'b0;
      #1;
      check("arst_dfp_read", 128'(bus.dfp_read), 128'(0));
      check("arst_dfp_write", 128'(bus.dfp_write), 128'(0));
      check("arst_dfp_wdata", 128'(bus.dfp_wdata), 128'(0));
      check("arst_rsp_valid", 128'(bus.rsp_valid), 128'(0));
      check("arst_rsp_rdata", bus.rsp_rdata, 128'(0));
      check("arst_rsp_err", 128'(bus.rsp_err), 128'(0));
      repeat (2) step();
      exp_bus.delete();
      rst_n = 1'b1;
      step();
      check("post_reset_ready", 128'(bus.req_ready), 128'(1));
      issue(1'b0, 32'h2000, 32'h2000, 128'(0), L4, 1'b0, 8);

      repeat (5) step();
      check("bus_beats_consumed", 128'(exp_bus.size()), 128'(0));
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: got no completion by 500us, expected summary");
      $fatal(1, "watchdog expired");
   end
endmodule
